instruction_fetch_unit: RTL

Program sequencer and instruction decoder for the mini CPU. It drives the instruction ROM address, registers the returned 28-bit instruction into an instruction register (IR), and presents decoded fields to the datapath. It resolves `JMP`/`BLE` control flow using a branch condition returned by the datapath, and implements `NOP` as a programmable stall. Two stages: Fetch (PC → ROM → IR) and Execute (IR decoded, consumed by datapath).

---
 rtl/instruction_fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Program sequencer and decoder: PC drives the instruction ROM, the returned word lands in IR.
// Latency: 1 cycle from fetch to issue. A taken JMP/BLE costs 1 bubble. NOP N costs N waiting cycles.
// Backpressure: there is none from the datapath. The only stall source is a NOP, which freezes PC and IR while it counts.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'd0,
  parameter int unsigned NOP_CNT_W    = 24
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  input  logic        iBranchTaken,
  output logic        oValid,
  output logic [3:0]  oOpcode,
  output logic [7:0]  oDest,
  output logic [7:0]  oSrc1,
  output logic [7:0]  oSrc0,
  output logic [15:0] oImm16,
  output logic        oWaiting
);

  // Opcode encodings shared with the datapath and assembler.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_LED = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_BLE = 4'h6;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                 state_q;
  logic [15:0]            pc_q;
  logic [27:0]            ir_q;
  logic                   vld_q;
  logic                   waiting_q;
  logic [NOP_CNT_W-1:0]   cnt_q;

  // Execute-stage decisions. All of them are derived from the IR and gated by the valid bit.
  logic                   exec_jmp;
  logic                   exec_ble;
  logic                   exec_nop;
  logic                   redirect;
  logic                   stall_start;
  logic [15:0]            target_pc;
  logic [15:0]            pc_inc;
  logic [NOP_CNT_W-1:0]   nop_operand;
  logic                   cnt_done;

  // Classify the instruction in Execute. Bubbles never redirect or stall.
  always_comb begin
    exec_jmp    = 1'b0;
    exec_ble    = 1'b0;
    exec_nop    = 1'b0;
    redirect    = 1'b0;
    stall_start = 1'b0;
    if (vld_q) begin
      exec_jmp = (ir_q[27:24] == OP_JMP);
      exec_ble = (ir_q[27:24] == OP_BLE);
      exec_nop = (ir_q[27:24] == OP_NOP);
    end
    // iBranchTaken only matters when a valid BLE sits in Execute.
    redirect    = exec_jmp || (exec_ble && iBranchTaken);
    // NOP 0 behaves like any pass-through instruction.
    stall_start = exec_nop && (ir_q[23:0] != 24'd0);
  end

  // Jump targets are 8 bits wide and zero-extended into the 16-bit PC.
  assign target_pc   = {8'b0, ir_q[23:16]};
  assign pc_inc      = pc_q + 16'd1;
  assign nop_operand = NOP_CNT_W'(ir_q[23:0]);
  assign cnt_done    = (cnt_q == '0);

  // Sequencer FSM. It owns PC, IR, the valid bit, the stall counter and the registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      ir_q      <= '0;
      vld_q     <= 1'b0;
      waiting_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
            // The word fetched alongside the branch is on the wrong path, so drop it.
            pc_q      <= target_pc;
            ir_q      <= '0;
            vld_q     <= 1'b0;
            waiting_q <= 1'b0;
          end else if (stall_start) begin
            // The NOP's own issue cycle counts as one of its N+1 cycles.
            // Hold PC and IR, and count the remaining N cycles down from N-1.
            state_q   <= ST_WAIT;
            cnt_q     <= nop_operand - NOP_CNT_W'(1);
            vld_q     <= 1'b0;
            waiting_q <= 1'b1;
          end else begin
            ir_q      <= iInstruction;
            vld_q     <= 1'b1;
            pc_q      <= pc_inc;
            waiting_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_done) begin
            // The ROM has been presenting PC the whole time, so issue it now.
            state_q   <= ST_RUN;
            ir_q      <= iInstruction;
            vld_q     <= 1'b1;
            pc_q      <= pc_inc;
            waiting_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - NOP_CNT_W'(1);
          end
        end
        default: begin
          state_q   <= ST_RUN;
          vld_q     <= 1'b0;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

  // Field extraction is a pure function of the IR. Consumers qualify it with oValid.
  assign oAddress = pc_q;
  assign oValid   = vld_q;
  assign oWaiting = waiting_q;
  assign oOpcode  = ir_q[27:24];
  assign oDest    = ir_q[23:16];
  assign oSrc1    = ir_q[15:8];
  assign oSrc0    = ir_q[7:0];
  assign oImm16   = ir_q[15:0];

endmodule
